// File: rtl/tpu_loader.sv
// tpu_loader: streams a 4x4 A and a 4x4 W operand matrix (8-bit elements) into a
// systolic array, starts it, waits for completion, then reads out the 16 P
// elements as a valid/ready byte stream.
//
// Ports
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_data : operand byte stream (A[0..15] then W[0..15], row-major)
//   m_valid/m_ready/m_data : result byte stream (P[0..15], row-major)
//   tpu_data_in, tpu_wr_addr, tpu_rd_addr, tpu_mem_acc, tpu_start : array controls
//   tpu_busy, tpu_data_out : array status and read data (read latency 1)
//   active               : high whenever a job is in progress
//   done                 : one-cycle pulse after the last P byte is accepted
module tpu_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic [7:0] tpu_data_in,
  output logic [3:0] tpu_wr_addr,
  output logic [3:0] tpu_rd_addr,
  output logic [1:0] tpu_mem_acc,
  output logic       tpu_start,
  input  logic       tpu_busy,
  input  logic [7:0] tpu_data_out,
  output logic       active,
  output logic       done
);

  localparam logic [1:0] AccIdle = 2'b00;
  localparam logic [1:0] AccWrA  = 2'b01;
  localparam logic [1:0] AccWrW  = 2'b10;
  localparam logic [1:0] AccRdP  = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StLoadA,
    StLoadW,
    StStart,
    StWaitHi,
    StWaitLo,
    StRdAddr,
    StRdCap,
    StSend
  } state_e;

  state_e     r_state;
  logic [3:0] r_idx;
  logic [2:0] r_guard;
  logic       r_s_ready;
  logic       r_m_valid;
  logic [7:0] r_m_data;
  logic [7:0] r_tpu_data_in;
  logic [3:0] r_wr_addr;
  logic [3:0] r_rd_addr;
  logic [1:0] r_mem_acc;
  logic       r_start;
  logic       r_active;
  logic       r_done;

  logic w_hs;

  // s_ready is only ever high in IDLE/LOAD_A/LOAD_W, so this is the operand handshake.
  assign w_hs = s_valid & r_s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_idx         <= 4'd0;
      r_guard       <= 3'd0;
      r_s_ready     <= 1'b1;
      r_m_valid     <= 1'b0;
      r_m_data      <= 8'd0;
      r_tpu_data_in <= 8'd0;
      r_wr_addr     <= 4'd0;
      r_rd_addr     <= 4'd0;
      r_mem_acc     <= AccIdle;
      r_start       <= 1'b0;
      r_active      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // Single-cycle strobes default low each cycle.
      r_mem_acc <= AccIdle;
      r_start   <= 1'b0;
      r_done    <= 1'b0;

      unique case (r_state)
        StIdle, StLoadA, StLoadW: begin
          if (w_hs) begin
            r_tpu_data_in <= s_data;
            r_wr_addr     <= r_idx;
            r_idx         <= r_idx + 4'd1;
            r_mem_acc     <= (r_state == StLoadW) ? AccWrW : AccWrA;
            if (r_state == StIdle) begin
              r_state  <= StLoadA;
              r_active <= 1'b1;
            end else if (r_idx == 4'd15) begin
              if (r_state == StLoadA) begin
                r_state <= StLoadW;
              end else begin
                r_state   <= StStart;
                r_s_ready <= 1'b0;
              end
            end
          end
        end

        StStart: begin
          r_start <= 1'b1;
          r_guard <= 3'd0;
          r_state <= StWaitHi;
        end

        // The guard lets a job finish even if the array never raises busy.
        StWaitHi: begin
          if (tpu_busy || (r_guard == 3'd7)) begin
            r_guard <= 3'd0;
            r_state <= StWaitLo;
          end else begin
            r_guard <= r_guard + 3'd1;
          end
        end

        // The read strobe is registered on entry so it is visible during RD_ADDR itself.
        StWaitLo: begin
          if (!tpu_busy) begin
            r_idx     <= 4'd0;
            r_rd_addr <= 4'd0;
            r_mem_acc <= AccRdP;
            r_state   <= StRdAddr;
          end
        end

        StRdAddr: begin
          r_state <= StRdCap;
        end

        // Read data arrives one cycle after the address cycle; capturing it on entry
        // to SEND keeps m_valid high for every cycle spent in SEND.
        StRdCap: begin
          r_m_data  <= tpu_data_out;
          r_m_valid <= 1'b1;
          r_state   <= StSend;
        end

        StSend: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_idx     <= r_idx + 4'd1;
            if (r_idx == 4'd15) begin
              r_state   <= StIdle;
              r_done    <= 1'b1;
              r_s_ready <= 1'b1;
              r_active  <= 1'b0;
            end else begin
              r_rd_addr <= r_idx + 4'd1;
              r_mem_acc <= AccRdP;
              r_state   <= StRdAddr;
            end
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign s_ready     = r_s_ready;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign tpu_data_in = r_tpu_data_in;
  assign tpu_wr_addr = r_wr_addr;
  assign tpu_rd_addr = r_rd_addr;
  assign tpu_mem_acc = r_mem_acc;
  assign tpu_start   = r_start;
  assign active      = r_active;
  assign done        = r_done;

endmodule

// File: tb/tb_tpu_loader.sv
// Scoreboard bench for tpu_loader: a driver issues operand jobs and pushes expected
// array writes and expected P bytes (4x4 matrix product mod 256) into queues; a
// negedge monitor pops and compares whenever the DUT writes the array or hands
// over a result byte. A small behavioural array model answers reads and busy.
module tb_tpu_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b1;
  logic [7:0] tpu_data_in;
  logic [3:0] tpu_wr_addr;
  logic [3:0] tpu_rd_addr;
  logic [1:0] tpu_mem_acc;
  logic       tpu_start;
  logic       tpu_busy = 1'b0;
  logic [7:0] tpu_data_out = 8'd0;
  logic       active;
  logic       done;

  always #5 clk = ~clk;

  tpu_loader dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .tpu_data_in  (tpu_data_in),
    .tpu_wr_addr  (tpu_wr_addr),
    .tpu_rd_addr  (tpu_rd_addr),
    .tpu_mem_acc  (tpu_mem_acc),
    .tpu_start    (tpu_start),
    .tpu_busy     (tpu_busy),
    .tpu_data_out (tpu_data_out),
    .active       (active),
    .done         (done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Job parameters shared between driver, array model and monitor.
  int   job_blen = 0;
  logic job_b2b = 1'b0;
  logic rd_fast = 1'b0;
  logic rd_stall = 1'b0;
  logic rd_rnd = 1'b0;
  int   exp_jobs = 0;

  logic [13:0] wq[$];
  logic [7:0]  pq[$];
  logic [7:0]  stim[32];
  logic [7:0]  a0[16] = '{4, 0, 2, 1, 4, 3, 2, 0, 4, 3, 0, 1, 4, 3, 2, 1};

  // Array model: write ports, latency-1 read port, product computed on start,
  // busy high for job_blen cycles (0 = never rises).
  logic [7:0] amem[16];
  logic [7:0] wmem[16];
  logic [7:0] pmem[16];
  int   busy_left = 0;
  logic rst_seen = 1'b0;

  function automatic logic [7:0] arr_elem(input int e);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 4; k++) s = s + amem[(e / 4) * 4 + k] * wmem[k * 4 + (e % 4)];
    return s;
  endfunction

  always @(posedge clk) begin
    rst_seen <= rst;
    if (tpu_mem_acc == 2'b01) amem[tpu_wr_addr] <= tpu_data_in;
    if (tpu_mem_acc == 2'b10) wmem[tpu_wr_addr] <= tpu_data_in;
    if (tpu_mem_acc == 2'b11) tpu_data_out <= pmem[tpu_rd_addr];
    if (tpu_start) begin
      for (int e = 0; e < 16; e++) pmem[e] <= arr_elem(e);
      busy_left <= job_blen;
      tpu_busy  <= (job_blen > 0);
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      tpu_busy  <= 1'b0;
    end
  end

  // Monitor state.
  int         cyc = 0;
  int         out_cnt = 0;
  int         in_cnt = 0;
  int         done_cnt = 0;
  int         starts = 0;
  int         start_cyc = 0;
  int         last_acc = 0;
  logic       busy_seen = 1'b0;
  logic       rd_pending = 1'b0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'd0;
  logic       done_q = 1'b0;
  logic [13:0] we;
  logic [7:0]  pe;

  always @(negedge clk) begin
    cyc++;
    if (rst_seen) begin
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_mem_acc", 32'(tpu_mem_acc), 32'd0);
      chk("rst_addrs", 32'({tpu_wr_addr, tpu_rd_addr}), 32'd0);
      chk("rst_data_in", 32'(tpu_data_in), 32'd0);
      chk("rst_start_active_done", 32'({tpu_start, active, done}), 32'd0);
      out_cnt = 0;
      in_cnt = 0;
      hold_v = 1'b0;
      rd_pending = 1'b0;
      done_q = 1'b0;
    end else begin
      if (tpu_mem_acc == 2'b01 || tpu_mem_acc == 2'b10) begin
        if (wq.size() == 0) begin
          chk("spurious_write", 32'({tpu_mem_acc, tpu_wr_addr}), 32'd0);
        end else begin
          we = wq.pop_front();
          chk("array_write", 32'({tpu_mem_acc, tpu_wr_addr, tpu_data_in}), 32'(we));
        end
      end
      if (s_valid && s_ready) begin
        if (in_cnt == 0 && job_b2b) chk("b2b_start_with_done", 32'(done), 32'd1);
        in_cnt = (in_cnt == 31) ? 0 : in_cnt + 1;
      end
      if (tpu_start) begin
        starts++;
        start_cyc = cyc;
        busy_seen = 1'b0;
        rd_pending = 1'b1;
      end
      if (tpu_busy) busy_seen = 1'b1;
      if (tpu_mem_acc == 2'b11 && rd_pending) begin
        rd_pending = 1'b0;
        if (!busy_seen) chk("guard_exit_latency", 32'(cyc - start_cyc), 32'd9);
      end
      if (hold_v) begin
        chk("stall_valid_held", 32'(m_valid), 32'd1);
        chk("stall_data_stable", 32'(m_data), 32'(hold_d));
      end
      if (m_valid && m_ready) begin
        if (pq.size() == 0) begin
          chk("extra_p_byte", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          pe = pq.pop_front();
          chk("p_byte", 32'(m_data), 32'(pe));
        end
        if (rd_fast && out_cnt > 0) chk("read_throughput", 32'(cyc - last_acc), 32'd3);
        last_acc = cyc;
        out_cnt++;
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      if (done) begin
        done_cnt++;
        chk("done_after_16", 32'(out_cnt), 32'd16);
        chk("done_one_cycle", 32'(done_q), 32'd0);
        out_cnt = 0;
      end
      done_q = done;
    end
  end

  // Downstream ready: optionally random, with one 5-cycle stall at P[7].
  int stall_left = 5;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_stall && stall_left > 0 && m_valid && out_cnt == 7) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = rd_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic send_byte(input int i);
    logic r;
    int   n;
    s_valid = 1'b1;
    s_data  = stim[i];
    n = 0;
    r = 1'b0;
    while (!r && n < 500) begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) chk("s_ready_timeout", 32'd0, 32'd1);
    else wq.push_back({(i < 16) ? 2'b01 : 2'b10, 4'(i % 16), stim[i]});
  endtask

  task automatic run_job(input bit ident, input int gapa, input int gapb, input int abort_at,
                         input int blen, input bit b2b, input bit fast, input bit stall,
                         input bit rnd, input bit wait_done);
    int s;
    int n;
    job_blen = blen;
    job_b2b  = b2b;
    for (int i = 0; i < 16; i++) begin
      stim[i]      = ident ? a0[i] : 8'($urandom);
      stim[16 + i] = ident ? ((i % 5 == 0) ? 8'd1 : 8'd0) : 8'($urandom);
    end
    for (int i = 0; i < 32; i++) begin
      if (i == abort_at) begin
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        job_b2b = 1'b0;
        return;
      end
      if (i == gapa || i == gapb) begin
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      send_byte(i);
    end
    // Expected result: P = A x W, each element mod 256.
    for (int e = 0; e < 16; e++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += int'(stim[(e / 4) * 4 + k]) * int'(stim[16 + k * 4 + e % 4]);
      pq.push_back(8'(s % 256));
    end
    rd_fast  = fast;
    rd_stall = stall;
    rd_rnd   = rnd;
    exp_jobs++;
    // Keep offering junk while the array runs; none of it may be written.
    s_valid = 1'b1;
    n = 0;
    while (!m_valid && n < 200) begin
      s_data = 8'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    if (!m_valid) chk("readout_start_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (done_cnt < exp_jobs && n < 500) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (done_cnt < exp_jobs) chk("done_timeout", 32'(done_cnt), 32'(exp_jobs));
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // ident gapa gapb abort blen b2b fast stall rnd wait
    run_job(1'b1, 0, 0, 99, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_job(1'b0, 4, 21, 99, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_job(1'b0, 0, 0, 25, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_job(1'b0, 0, 0, 99, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_job(1'b0, 0, 0, 99, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_job(1'b0, 7, 0, 99, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (done_cnt < exp_jobs && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("done_count", 32'(done_cnt), 32'(exp_jobs));
    chk("start_count", 32'(starts), 32'(exp_jobs));
    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("p_bytes_drained", 32'(pq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
